// File: rtl/board_scan_driver.sv
// Connect-4 LED matrix scanner: snapshots the board at frame boundaries and
// multiplexes it onto a 6x7 bicolour matrix, blinking the winning line after game over.
module board_scan_driver #(
  parameter int TICKS_PER_ROW = 1000,
  parameter int BLINK_FRAMES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [41:0] occupied,
  input  logic [41:0] owner,
  input  logic [41:0] win_mask,
  input  logic        game_over,
  output logic [5:0]  row_sel,
  output logic [6:0]  red_col,
  output logic [6:0]  grn_col,
  output logic        frame_start,
  output logic        blink_phase
);

  localparam int TW = $clog2(TICKS_PER_ROW);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_ROW - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      row_q, row_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            blink_q, blink_d;
  logic            pend_vld_q, pend_vld_d;
  logic [41:0]     pend_occ_q, pend_occ_d, pend_own_q, pend_own_d, pend_win_q, pend_win_d;
  logic [41:0]     sh_occ_q, sh_occ_d, sh_own_q, sh_own_d, sh_win_q, sh_win_d;
  logic [5:0]      row_sel_q, row_sel_d;
  logic [6:0]      red_q, red_d, grn_q, grn_d;
  logic            fstart_q, fstart_d;
  logic            tick_wrap, row_wrap, frame_wrap;
  logic [6:0]      occ_row, own_row, win_row, on_row;

  always_comb begin
    tick_wrap  = (tick_q == TICK_LAST);
    row_wrap   = tick_wrap && (row_q == 3'd5);
    frame_wrap = row_wrap && (frame_q == FRAME_LAST);

    tick_d  = tick_wrap ? '0 : tick_q + 1'b1;
    row_d   = row_wrap ? 3'd0 : (tick_wrap ? row_q + 3'd1 : row_q);
    frame_d = frame_wrap ? '0 : (row_wrap ? frame_q + 1'b1 : frame_q);
    blink_d = blink_q ^ frame_wrap;

    pend_vld_d = pend_vld_q;
    pend_occ_d = pend_occ_q;
    pend_own_d = pend_own_q;
    pend_win_d = pend_win_q;
    sh_occ_d   = sh_occ_q;
    sh_own_d   = sh_own_q;
    sh_win_d   = sh_win_q;
    // A load coinciding with the frame edge bypasses the pending stage
    if (row_wrap) begin
      pend_vld_d = 1'b0;
      if (load) begin
        sh_occ_d = occupied;
        sh_own_d = owner;
        sh_win_d = win_mask;
      end else if (pend_vld_q) begin
        sh_occ_d = pend_occ_q;
        sh_own_d = pend_own_q;
        sh_win_d = pend_win_q;
      end
    end else if (load) begin
      pend_vld_d = 1'b1;
      pend_occ_d = occupied;
      pend_own_d = owner;
      pend_win_d = win_mask;
    end

    state_d = (tick_d >= TW'(2)) ? ST_DRIVE : ST_BLANK;

    // Outputs are computed from next state so the registers line up with (row, tick)
    occ_row = 7'(sh_occ_d >> (7 * row_d));
    own_row = 7'(sh_own_d >> (7 * row_d));
    win_row = 7'(sh_win_d >> (7 * row_d));
    on_row  = occ_row & ~({7{game_over & blink_d}} & win_row);

    row_sel_d = '0;
    red_d     = '0;
    grn_d     = '0;
    if (state_d == ST_DRIVE) begin
      row_sel_d = 6'd1 << row_d;
      red_d     = on_row & ~own_row;
      grn_d     = on_row & own_row;
    end
    fstart_d = (row_d == 3'd0) && (tick_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BLANK;
      tick_q     <= '0;
      row_q      <= '0;
      frame_q    <= '0;
      blink_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_occ_q <= '0;
      pend_own_q <= '0;
      pend_win_q <= '0;
      sh_occ_q   <= '0;
      sh_own_q   <= '0;
      sh_win_q   <= '0;
      row_sel_q  <= '0;
      red_q      <= '0;
      grn_q      <= '0;
      fstart_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      row_q      <= row_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      pend_vld_q <= pend_vld_d;
      pend_occ_q <= pend_occ_d;
      pend_own_q <= pend_own_d;
      pend_win_q <= pend_win_d;
      sh_occ_q   <= sh_occ_d;
      sh_own_q   <= sh_own_d;
      sh_win_q   <= sh_win_d;
      row_sel_q  <= row_sel_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      fstart_q   <= fstart_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign red_col     = red_q;
  assign grn_col     = grn_q;
  assign frame_start = fstart_q;
  assign blink_phase = blink_q;

endmodule

// File: tb/tb_board_scan_driver.sv
// Bench for board_scan_driver: directed scenarios plus random loads, every cycle
// compared against a cycle-count based reference model of the display.
module tb_board_scan_driver;
  localparam int T  = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * T;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        game_over = 1'b0;
  logic [41:0] occupied = '0, owner = '0, win_mask = '0;
  logic [5:0]  row_sel;
  logic [6:0]  red_col, grn_col;
  logic        frame_start, blink_phase;

  board_scan_driver #(.TICKS_PER_ROW(T), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .load(load), .occupied(occupied), .owner(owner),
    .win_mask(win_mask), .game_over(game_over), .row_sel(row_sel), .red_col(red_col),
    .grn_col(grn_col), .frame_start(frame_start), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n;
  logic [41:0] s_occ, s_own, s_win, p_occ, p_own, p_win;
  bit pv, go_s;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; pv = 0; go_s = 0;
    s_occ = '0; s_own = '0; s_win = '0;
    p_occ = '0; p_own = '0; p_win = '0;
  endtask

  // Expected display derived from elapsed cycles since reset release
  task automatic check_outputs();
    int tk, rw, idx;
    bit bl, on;
    logic [5:0] ers;
    logic [6:0] er, eg;
    tk = n % T;
    rw = (n / T) % 6;
    bl = ((n / FRAME) / BF) % 2 == 1;
    ers = '0; er = '0; eg = '0;
    if (tk >= 2) begin
      ers = 6'(1 << rw);
      for (int c = 0; c < 7; c++) begin
        idx = rw * 7 + c;
        on = s_occ[idx] && !(go_s && s_win[idx] && bl);
        er[c] = on && !s_own[idx];
        eg[c] = on && s_own[idx];
      end
    end
    chk("row_sel", 32'(row_sel), 32'(ers));
    chk("red_col", 32'(red_col), 32'(er));
    chk("grn_col", 32'(grn_col), 32'(eg));
    chk("frame_start", 32'(frame_start), 32'(n % FRAME == 0));
    chk("blink_phase", 32'(blink_phase), 32'(bl));
    chk("onehot0", 32'($onehot0(row_sel)), 32'd1);
    chk("no_overlap", 32'(red_col & grn_col), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    go_s = game_over;
    if (n % FRAME == FRAME - 1) begin
      if (load) begin
        s_occ = occupied; s_own = owner; s_win = win_mask;
      end else if (pv) begin
        s_occ = p_occ; s_own = p_own; s_win = p_win;
      end
      pv = 0;
    end else if (load) begin
      p_occ = occupied; p_own = owner; p_win = win_mask; pv = 1;
    end
    n++;
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic run_to(input int k);
    for (int g = 0; g < 2 * FRAME && (n % FRAME) != k; g++) step();
    chk("run_to", 32'(n % FRAME), 32'(k));
  endtask

  task automatic do_load(input logic [41:0] o, input logic [41:0] w, input logic [41:0] m);
    occupied = o; owner = w; win_mask = m; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  function automatic logic [41:0] rnd42();
    return 42'({$urandom(), $urandom()});
  endfunction

  initial begin
    // Reset state held
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Colour mapping, loaded mid-frame
    run_to(10);
    do_load(42'h1 | (42'h1 << 8), 42'h1 << 8, '0);
    run_to(2);
    chk("colour_r0_red", 32'(red_col), 32'h01);
    chk("colour_r0_grn", 32'(grn_col), 32'h00);
    run_to(6);
    chk("colour_r1_red", 32'(red_col), 32'h00);
    chk("colour_r1_grn", 32'(grn_col), 32'h02);

    // Overwrite within a frame, then load on the last cycle of row 5
    run_to(5);
    do_load(42'h7F, '0, '0);
    run_to(9);
    do_load(42'h3, 42'h3, '0);
    run_to(2);
    chk("overwrite_grn", 32'(grn_col), 32'h03);
    run_to(FRAME - 1);
    do_load(42'h55, 42'h0, '0);
    run_to(2);
    chk("late_load_red", 32'(red_col), 32'h55);

    // Blink on the winning line, then stop blinking
    do_load(42'hF, '0, 42'hF);
    game_over = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) step();
    game_over = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) step();

    // Asynchronous reset while driving row 3 with a pending load
    do_load(rnd42() | (42'h1 << 21), rnd42() & ~(42'h1 << 21), '0);
    run_to(14);
    do_load(rnd42(), rnd42(), rnd42());
    chk("pre_reset_row3", 32'(row_sel), 32'h08);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Random loads over 100 frames
    for (int i = 0; i < 100 * FRAME; i++) begin
      load = ($urandom_range(0, 7) == 0);
      occupied = rnd42(); owner = rnd42(); win_mask = rnd42();
      if ($urandom_range(0, 49) == 0) game_over = ~game_over;
      step();
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_scan_driver.md
# board_scan_driver

Downstream display stage for the Connect-4 game core. Takes the game board as two 42-bit planes (occupancy, owner) plus a winning-cell mask, snapshots them tear-free at frame boundaries, and time-multiplexes them onto a 6-row × 7-column bicolour LED matrix. Winning cells blink after game over. Sits between the game core's board/status outputs and the FPGA LED and pin outputs.

## Interface
- TICKS_PER_ROW, default 1000: clock cycles per row slot; legal range ≥ 3.
- BLINK_FRAMES, default 32: full frames per blink half-period; legal range ≥ 1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle request to capture occupied/owner/win_mask.
- occupied  in  42  bit i = 1 when cell i holds a disc; i = row*7 + col, row 0 at the bottom.
- owner  in  42  bit i = 0 for player 1 (red), 1 for player 2 (green); ignored where occupied[i] = 0.
- win_mask  in  42  cells forming the winning line.
- game_over  in  1  level signal; enables blinking (used live, not snapshotted).
- row_sel  out  6  one-hot row drive, active high.
- red_col  out  7  red column data for the driven row.
- grn_col  out  7  green column data for the driven row.
- frame_start  out  1  one-cycle pulse at the start of each frame.
- blink_phase  out  1  current blink half-period (1 = blanked phase).

## Operation
- **Counters.**
  - tick counts 0..TICKS_PER_ROW-1.
  - row counts 0..5. row increments when tick wraps; row wraps 5→0.
  - frame_cnt counts 0..BLINK_FRAMES-1 and increments on each row 5→0 wrap.
  - blink_phase toggles when frame_cnt wraps.
- **Two-state scan FSM per row slot.**
  - BLANK at tick 0 and tick 1: row_sel = 0, red_col = 0, grn_col = 0 (anti-ghosting).
  - DRIVE at tick 2..TICKS_PER_ROW-1: row_sel = 1 << row.
- **Column data for col c, cell i = row*7 + c, while in DRIVE.**
  - on = occupied_s[i] & ~(game_over & win_mask_s[i] & blink_phase).
  - red_col[c] = on & ~owner_s[i].
  - grn_col[c] = on & owner_s[i].
- **Snapshot rules.** The _s suffix marks the shadow registers.
  - load captures the inputs into pending registers and sets pending_valid.
  - A later load before commit overwrites the pending registers.
  - Commit to the shadow happens on the edge where row 5/tick T-1 advances to row 0/tick 0.
  - If load is high in that same cycle, the live inputs are committed directly. pending_valid then clears.
  - With no pending data, the shadow holds its value.
- **game_over.** Deassertion stops blinking immediately. blink_phase keeps counting regardless of game_over.
- **frame_start.** High exactly while row = 0 and tick = 0.

## Timing
- **Outputs.** All outputs are registered and aligned with the current (row, tick) state; no combinational input-to-output path.
- **Reset values.** row = 0, tick = 0, frame_cnt = 0, blink_phase = 0, pending_valid = 0, shadow = 0, pending = 0, row_sel = 0, red_col = 0, grn_col = 0.
  - frame_start reads 1 during reset, because row = 0 and tick = 0.
- **Reset mid-frame.** Asynchronous assertion clears everything at once, including any uncommitted pending load.
- **Startup.** The first active clock edge after reset release advances tick to 1.
- **Periods.**
  - Frame period = 6 × TICKS_PER_ROW cycles.
  - Blink half-period = BLINK_FRAMES frames.
- **Load latency.** A load is visible starting at the next frame_start. The worst case is one frame + 1 cycle.
- **Blink phase.** blink_phase changes on the same edge that raises frame_start. The blink state never changes mid-frame.

## Test plan
All scenarios use TICKS_PER_ROW = 4 and BLINK_FRAMES = 2.
- **Reset state.** Hold reset low, then release.
  - During reset: row_sel = 0, cols = 0, blink_phase = 0, frame_start = 1.
  - After release: row_sel sequence is 0, 0, 000001, 000001, 0, 0, 000010, …; frame_start pulses every 24 cycles.
- **Colour mapping.** Pulse load with occupied = bit0 | bit8 and owner = bit8, mid-frame.
  - Before the next frame: all columns = 0.
  - After the next frame_start: row 0 gives red_col = 0000001, grn_col = 0; row 1 gives red_col = 0, grn_col = 0000010.
- **Tear-free and overwrite.**
  - Pulse load A, then load B in the same frame: only B appears at the next frame.
  - Pulse load C in the last cycle of row 5: C is shown in the immediately following frame.
- **Blink.** occupied = win_mask = bits 0..3, owner = 0, game_over = 1.
  - Row 0 red_col = 0001111 for frames 0–1 and 0000000 for frames 2–3; the pattern repeats.
  - With game_over = 0 the cells stay lit.
- **Async reset mid-operation.** Assert reset at row 3 with a pending load.
  - Outputs go to 0 immediately, without a clock edge.
  - After release the display is blank until a new load is committed.
- **Blanking invariant.** Run random loads over 100 frames.
  - row_sel is never multi-hot.
  - Columns are 0 whenever row_sel = 0.
  - red_col & grn_col = 0 always.
